// File: rtl/hazard_stall_controller.sv
// Load-use hazard and branch/jump flush controller for the ID/EX pipeline register.
// State and performance counters update on the falling clock edge, like the pipeline registers.
module hazard_stall_controller #(
  parameter int NBits             = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_BITS          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NBits-1:0]    in_Instruction,
  input  logic                in_UsesRs,
  input  logic                in_UsesRt,
  input  logic                in_ExCtrlMemRead,
  input  logic                in_ExCtrlRegWrite,
  input  logic [4:0]          in_ExWriteRegister,
  input  logic                in_ExBranchTaken,
  input  logic                in_ExCtrlJump,
  output logic                out_PCWrite,
  output logic                out_IFIDWrite,
  output logic                out_IFIDFlush,
  output logic                out_IDEXBubble,
  output logic [1:0]          out_State,
  output logic [CNT_BITS-1:0] out_StallCount,
  output logic [CNT_BITS-1:0] out_FlushCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1
  } stateT;

  localparam logic [3:0] StallReload = 4'(LOAD_STALL_CYCLES - 1);
  localparam bit         MultiCycle  = (LOAD_STALL_CYCLES > 1);

  stateT               state, nextState;
  logic [3:0]          stallCnt, nextStallCnt;
  logic [CNT_BITS-1:0] stallCount, flushCount;
  logic                hazard, flush;
  logic                pcWrite, ifidWrite, ifidFlush, idexBubble;
  logic [4:0]          rs, rt;
  logic                unusedInstrBits;

  assign rs = in_Instruction[25:21];
  assign rt = in_Instruction[20:16];
  assign unusedInstrBits = ^{in_Instruction[NBits-1:26], in_Instruction[15:0]};

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign hazard = in_ExCtrlMemRead & in_ExCtrlRegWrite & (in_ExWriteRegister != 5'd0) &
                  ((in_UsesRs & (rs == in_ExWriteRegister)) |
                   (in_UsesRt & (rt == in_ExWriteRegister)));
  assign flush  = in_ExBranchTaken | in_ExCtrlJump;

  always_comb begin
    nextState    = state;
    nextStallCnt = stallCnt;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    ifidFlush    = 1'b0;
    idexBubble   = 1'b0;
    unique case (state)
      RUN: begin
        if (flush) begin
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
        end else if (hazard) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
          if (MultiCycle) begin
            nextState    = STALL;
            nextStallCnt = StallReload;
          end
        end
      end
      STALL: begin
        // EX holds a bubble here, so its inputs are deliberately ignored.
        pcWrite      = 1'b0;
        ifidWrite    = 1'b0;
        idexBubble   = 1'b1;
        nextStallCnt = stallCnt - 4'd1;
        if (stallCnt == 4'd1) begin
          nextState = RUN;
        end
      end
      default: begin
        nextState    = RUN;
        nextStallCnt = 4'd0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      stallCnt   <= 4'd0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      state    <= nextState;
      stallCnt <= nextStallCnt;
      if (!pcWrite && (stallCount != '1)) begin
        stallCount <= stallCount + 1'b1;
      end
      if (ifidFlush && (flushCount != '1)) begin
        flushCount <= flushCount + 1'b1;
      end
    end
  end

  // While reset is held the pipeline is frozen and ID/EX is forced to a bubble.
  assign out_PCWrite    = reset & pcWrite;
  assign out_IFIDWrite  = reset & ifidWrite;
  assign out_IFIDFlush  = reset & ifidFlush;
  assign out_IDEXBubble = ~reset | idexBubble;
  assign out_State      = state;
  assign out_StallCount = stallCount;
  assign out_FlushCount = flushCount;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized bench for hazard_stall_controller: three configurations share one stimulus stream
// and are compared every cycle against a remaining-stall-cycles reference model.
module tb_hazard_stall_controller;

  localparam int NumDut = 3;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        usesRs, usesRt, memRead, regWrite, branchTaken, jump;
  logic [4:0]  writeReg;

  logic        pcw [NumDut];
  logic        ifw [NumDut];
  logic        ifl [NumDut];
  logic        bub [NumDut];
  logic [1:0]  st  [NumDut];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int          stallCycles [NumDut] = '{1, 3, 3};
  int unsigned countMax    [NumDut] = '{65535, 65535, 15};
  int          remaining   [NumDut];
  int unsigned modelStall  [NumDut];
  int unsigned modelFlush  [NumDut];

  int testCount = 0;
  int failCount = 0;

  hazard_stall_controller #(.NBits(32), .LOAD_STALL_CYCLES(1), .CNT_BITS(16)) dut0 (
    .clk(clk), .reset(reset), .in_Instruction(instr), .in_UsesRs(usesRs), .in_UsesRt(usesRt),
    .in_ExCtrlMemRead(memRead), .in_ExCtrlRegWrite(regWrite), .in_ExWriteRegister(writeReg),
    .in_ExBranchTaken(branchTaken), .in_ExCtrlJump(jump),
    .out_PCWrite(pcw[0]), .out_IFIDWrite(ifw[0]), .out_IFIDFlush(ifl[0]), .out_IDEXBubble(bub[0]),
    .out_State(st[0]), .out_StallCount(sc0), .out_FlushCount(fc0));

  hazard_stall_controller #(.NBits(32), .LOAD_STALL_CYCLES(3), .CNT_BITS(16)) dut1 (
    .clk(clk), .reset(reset), .in_Instruction(instr), .in_UsesRs(usesRs), .in_UsesRt(usesRt),
    .in_ExCtrlMemRead(memRead), .in_ExCtrlRegWrite(regWrite), .in_ExWriteRegister(writeReg),
    .in_ExBranchTaken(branchTaken), .in_ExCtrlJump(jump),
    .out_PCWrite(pcw[1]), .out_IFIDWrite(ifw[1]), .out_IFIDFlush(ifl[1]), .out_IDEXBubble(bub[1]),
    .out_State(st[1]), .out_StallCount(sc1), .out_FlushCount(fc1));

  hazard_stall_controller #(.NBits(32), .LOAD_STALL_CYCLES(3), .CNT_BITS(4)) dut2 (
    .clk(clk), .reset(reset), .in_Instruction(instr), .in_UsesRs(usesRs), .in_UsesRt(usesRt),
    .in_ExCtrlMemRead(memRead), .in_ExCtrlRegWrite(regWrite), .in_ExWriteRegister(writeReg),
    .in_ExBranchTaken(branchTaken), .in_ExCtrlJump(jump),
    .out_PCWrite(pcw[2]), .out_IFIDWrite(ifw[2]), .out_IFIDFlush(ifl[2]), .out_IDEXBubble(bub[2]),
    .out_State(st[2]), .out_StallCount(sc2), .out_FlushCount(fc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input logic rst, input logic mr, input logic rw, input logic [4:0] wr,
                               input logic [4:0] rsIn, input logic [4:0] rtIn, input logic ur,
                               input logic ut, input logic br, input logic jp);
    @(negedge clk);
    #1;
    reset       = rst;
    memRead     = mr;
    regWrite    = rw;
    writeReg    = wr;
    instr       = $urandom;
    instr[25:21] = rsIn;
    instr[20:16] = rtIn;
    usesRs      = ur;
    usesRt      = ut;
    branchTaken = br;
    jump        = jp;
    #3;
    checkCycle();
  endtask

  // Compares every instance against the model, then advances the model past the next falling edge.
  task automatic checkCycle();
    logic        hz, fl;
    logic [4:0]  rsF, rtF;
    logic        ePc, eIfw, eFl, eBub;
    logic [1:0]  eSt;
    logic [31:0] aSc, aFc;
    rsF = instr[25:21];
    rtF = instr[20:16];
    hz  = memRead && regWrite && (writeReg != 0) &&
          ((usesRs && rsF == writeReg) || (usesRt && rtF == writeReg));
    fl  = branchTaken || jump;
    for (int i = 0; i < NumDut; i++) begin
      if (!reset) begin
        remaining[i]  = 0;
        modelStall[i] = 0;
        modelFlush[i] = 0;
      end
      if (!reset)                {ePc, eIfw, eFl, eBub} = 4'b0001;
      else if (remaining[i] > 0) {ePc, eIfw, eFl, eBub} = 4'b0001;
      else if (fl)               {ePc, eIfw, eFl, eBub} = 4'b1111;
      else if (hz)               {ePc, eIfw, eFl, eBub} = 4'b0001;
      else                       {ePc, eIfw, eFl, eBub} = 4'b1100;
      eSt = (reset && remaining[i] > 0) ? 2'd1 : 2'd0;
      aSc = (i == 0) ? 32'(sc0) : (i == 1) ? 32'(sc1) : 32'(sc2);
      aFc = (i == 0) ? 32'(fc0) : (i == 1) ? 32'(fc1) : 32'(fc2);
      checkOutput($sformatf("pcWrite%0d", i), 32'(pcw[i]), 32'(ePc));
      checkOutput($sformatf("ifidWrite%0d", i), 32'(ifw[i]), 32'(eIfw));
      checkOutput($sformatf("ifidFlush%0d", i), 32'(ifl[i]), 32'(eFl));
      checkOutput($sformatf("idexBubble%0d", i), 32'(bub[i]), 32'(eBub));
      checkOutput($sformatf("state%0d", i), 32'(st[i]), 32'(eSt));
      checkOutput($sformatf("stallCount%0d", i), aSc, modelStall[i]);
      checkOutput($sformatf("flushCount%0d", i), aFc, modelFlush[i]);
      if (reset) begin
        if (remaining[i] > 0) begin
          remaining[i]--;
          if (modelStall[i] < countMax[i]) modelStall[i]++;
        end else if (fl) begin
          if (modelFlush[i] < countMax[i]) modelFlush[i]++;
        end else if (hz) begin
          remaining[i] = stallCycles[i] - 1;
          if (modelStall[i] < countMax[i]) modelStall[i]++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; instr = '0; usesRs = 0; usesRt = 0; memRead = 0; regWrite = 0;
    writeReg = '0; branchTaken = 0; jump = 0;
    for (int i = 0; i < NumDut; i++) begin
      remaining[i] = 0; modelStall[i] = 0; modelFlush[i] = 0;
    end

    // Reset held, with a live load-use pattern on the inputs that must be ignored.
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0);

    // Basic load-use on rs, followed by bubbles while any stall drains.
    applyStimulus(1, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 0, 5'd0, 5'd8, 5'd0, 1, 0, 0, 0);

    // Register 0 never hazards; unused rt never hazards.
    applyStimulus(1, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0);

    // Taken branch wins over a concurrent load-use match.
    applyStimulus(1, 1, 1, 5'd8, 5'd8, 5'd8, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);

    // Random traffic with narrow register range to provoke hazards, plus occasional resets.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
